rv32i_dbus_bridge: RTL and testbench

- Data-bus master between the load-store unit and system memory/peripherals.
- Accepts the LSU's single-cycle access (address, write enable, shifted write data, byte enables) and runs it as a Wishbone B4 classic cycle.
- Stalls the core until the bus acknowledges, then returns the registered raw read word to the LSU for extraction and sign extension.
- Flags bus errors and slave timeouts to the core.

---
 rtl/rv32i_dbus_bridge.sv | 99 +++++++++
 tb/tb_rv32i_dbus_bridge.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_dbus_bridge.sv
// RV32I data-bus master: turns the LSU's single-cycle access into a Wishbone B4
// classic cycle, stalling the core until ack, error or timeout.
module rv32i_dbus_bridge #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdat_i,
    input  logic [3:0]  be_i,
    output logic        stall_o,
    output logic [31:0] rdat_o,
    output logic        err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_ERR, S_DONE} state_t;

    localparam bit               TO_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? TIMEOUT - 1 : 0);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             timed_out;

    assign timed_out = TO_EN && (cnt == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Error wins over ack; DONE/ERR always fall back through IDLE so accesses never merge.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req_i) state_nxt = S_BUS;
            S_BUS: begin
                if (wb_err_i)       state_nxt = S_ERR;
                else if (wb_ack_i)  state_nxt = S_DONE;
                else if (timed_out) state_nxt = S_ERR;
            end
            S_ERR:   state_nxt = S_IDLE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_cyc_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_sel_o <= '0;
            rdat_o   <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_i) begin
                    wb_cyc_o <= 1'b1;
                    wb_we_o  <= we_i;
                    wb_adr_o <= addr_i & 32'hFFFF_FFFC;
                    wb_dat_o <= wdat_i;
                    wb_sel_o <= be_i;
                    cnt      <= '0;
                end
                S_BUS: begin
                    if (wb_err_i || (!wb_ack_i && timed_out)) begin
                        wb_cyc_o <= 1'b0;
                        rdat_o   <= '0;
                    end else if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        if (!wb_we_o) rdat_o <= wb_dat_i;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign wb_stb_o = wb_cyc_o;
    assign err_o    = (state == S_ERR);
    assign stall_o  = req_i & ((state == S_IDLE) | (state == S_BUS));

endmodule

// File: tb/tb_rv32i_dbus_bridge.sv
// Scoreboard bench for rv32i_dbus_bridge: directed accesses push expected results,
// a negedge monitor checks the Wishbone request and the retire response.
module tb_rv32i_dbus_bridge;

    logic        clk, rst_ni;
    logic        req_i, we_i;
    logic [31:0] addr_i, wdat_i;
    logic [3:0]  be_i;
    logic        stall_o, err_o;
    logic [31:0] rdat_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i, wb_err_i;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        err;
        logic [31:0] rdat;
    } exp_t;

    exp_t        q[$];
    int          cmp_cnt = 0;
    int          mis_cnt = 0;
    logic [31:0] last_rdat = 32'h0;

    // Slave model: mode 0 = ack, 1 = err+ack together, 2 = never respond
    logic [1:0]  slave_mode = 2'd2;
    logic [7:0]  slave_wait = 8'd0;
    logic [31:0] slave_data = 32'h0;
    logic        stray = 1'b0;
    logic [7:0]  wcnt;

    rv32i_dbus_bridge #(.TIMEOUT(4), .CNT_W(3)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .wdat_i(wdat_i), .be_i(be_i), .stall_o(stall_o),
        .rdat_o(rdat_o), .err_o(err_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) wcnt <= 8'd0;
        else         wcnt <= wb_cyc_o ? wcnt + 8'd1 : 8'd0;
    end

    assign wb_ack_i = stray | (wb_cyc_o && wb_stb_o && slave_mode != 2'd2 && wcnt == slave_wait);
    assign wb_err_i = wb_cyc_o && wb_stb_o && slave_mode == 2'd1 && wcnt == slave_wait;
    assign wb_dat_i = slave_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: request fields held for the whole cycle, response checked at retire
    always @(negedge clk) begin
        if (rst_ni && q.size() > 0) begin
            if (wb_cyc_o) begin
                chk("wb_stb", wb_stb_o, 1);
                chk("wb_we", wb_we_o, q[0].we);
                chk("wb_adr", wb_adr_o, q[0].adr);
                chk("wb_dat", wb_dat_o, q[0].dat);
                chk("wb_sel", wb_sel_o, q[0].sel);
            end
            if (req_i && !stall_o) begin
                chk("err_retire", err_o, q[0].err);
                chk("rdat_retire", rdat_o, q[0].rdat);
                void'(q.pop_front());
            end else begin
                chk("err_quiet", err_o, 0);
            end
        end
    end

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdat,
                          input logic [3:0] be, input logic [1:0] mode, input logic [7:0] waits,
                          input logic [31:0] data, input int exp_stall);
        exp_t e;
        int   n = 0;
        bit   done = 0;
        e.we  = we;
        e.adr = addr & 32'hFFFF_FFFC;
        e.dat = wdat;
        e.sel = be;
        e.err = (mode != 2'd0);
        if (e.err)   last_rdat = 32'h0;
        else if (!we) last_rdat = data;
        e.rdat = last_rdat;
        @(posedge clk); #1;
        slave_mode = mode; slave_wait = waits; slave_data = data;
        req_i = 1'b1; we_i = we; addr_i = addr; wdat_i = wdat; be_i = be;
        q.push_back(e);
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (stall_o) begin
                if (n == 0) chk("cyc_in_idle", wb_cyc_o, 0);
                if (n == 1) chk("cyc_in_bus", wb_cyc_o, 1);
                n++;
            end else begin
                done = 1;
            end
        end
        chk("retired", done, 1);
        chk("stall_cycles", n, exp_stall);
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        req_i = 1'b0; slave_mode = 2'd2;
    endtask

    initial begin
        rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0;
        addr_i = '0; wdat_i = '0; be_i = '0;
        #12;
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_sel", wb_sel_o, 0);
        chk("rst_rdat", rdat_o, 0);
        chk("rst_stall", stall_o, 0);
        @(negedge clk); rst_ni = 1'b1;

        // Unaligned load, zero-wait ack
        access(1'b0, 32'h0000_1006, 32'h0, 4'b1100, 2'd0, 8'd0, 32'hDEAD_BEEF, 2);
        go_idle();
        // Store with 3 wait states; read data on the bus must not reach rdat_o
        access(1'b1, 32'h0000_2000, 32'h0000_00AB, 4'b0001, 2'd0, 8'd3, 32'hCAFE_F00D, 5);
        go_idle();
        // err and ack together: error wins, rdat_o cleared
        access(1'b0, 32'h0000_3000, 32'h0, 4'b1111, 2'd1, 8'd0, 32'h1111_1111, 2);
        go_idle();

        // Ack outside BUS is ignored
        @(posedge clk); #1; stray = 1'b1; slave_data = 32'h9999_9999;
        @(negedge clk);
        chk("stray_err", err_o, 0);
        chk("stray_cyc", wb_cyc_o, 0);
        @(posedge clk); #1; stray = 1'b0;
        @(negedge clk);
        chk("stray_rdat", rdat_o, last_rdat);

        // Timeout after 4 BUS cycles, then back-to-back loads with req held
        access(1'b0, 32'h0000_4000, 32'h0, 4'b1111, 2'd2, 8'd0, 32'h0, 5);
        access(1'b0, 32'h0000_4004, 32'h0, 4'b1111, 2'd0, 8'd1, 32'h1234_5678, 3);
        access(1'b0, 32'h0000_5000, 32'h0, 4'b0011, 2'd0, 8'd0, 32'hA5A5_0001, 2);
        access(1'b0, 32'h0000_500B, 32'h0, 4'b1000, 2'd0, 8'd2, 32'h0BAD_CAFE, 4);
        go_idle();

        // Asynchronous reset in the middle of a BUS cycle
        @(posedge clk); #1;
        slave_mode = 2'd2; req_i = 1'b1; we_i = 1'b1;
        addr_i = 32'h0000_6000; wdat_i = 32'h5555_AAAA; be_i = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_cyc", wb_cyc_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_cyc", wb_cyc_o, 0);
        chk("async_stb", wb_stb_o, 0);
        chk("async_we", wb_we_o, 0);
        chk("async_adr", wb_adr_o, 0);
        chk("async_dat", wb_dat_o, 0);
        chk("async_rdat", rdat_o, 0);
        chk("async_err", err_o, 0);
        req_i = 1'b0;
        last_rdat = 32'h0;
        @(negedge clk); rst_ni = 1'b1;
        access(1'b0, 32'h0000_7000, 32'h0, 4'b1111, 2'd0, 8'd0, 32'h0000_0077, 2);
        go_idle();
        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
